// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch_timer slice.
//   MODE_UP / MODE_DOWN        : encoding of the `mode` level input.
//   SEC_MOD_DEFAULT / MIN_MOD_DEFAULT : default moduli of the two fields.
package stopwatch_pkg;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam int SEC_MOD_DEFAULT = 60;
    localparam int MIN_MOD_DEFAULT = 60;

endpackage

// File: rtl/mod_field.sv
// One modulo-MOD counter field (seconds or minutes of the stopwatch).
// Ports:
//   clk, rst : clock, asynchronous active-high reset (value -> 0)
//   inc      : increment modulo MOD this cycle
//   dec      : decrement modulo MOD this cycle
//   clr      : synchronous clear to 0 (wins over inc/dec)
//   val      : registered field value
//   carry    : combinational, high when this cycle's inc wraps MOD-1 -> 0
//   borrow   : combinational, high when this cycle's dec wraps 0 -> MOD-1
// Priority inside the field: clr > inc > dec.
module mod_field #(
    parameter int MOD = 60,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] val,
    output logic         carry,
    output logic         borrow
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (inc) begin
            val_d = (val_q == TOP) ? '0 : val_q + 1'b1;
        end else if (dec) begin
            val_d = (val_q == '0) ? TOP : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val    = val_q;
    assign carry  = inc && !clr && (val_q == TOP);
    assign borrow = dec && !inc && !clr && (val_q == '0);

endmodule

// File: rtl/stopwatch_timer.sv
// Minutes:seconds stopwatch / countdown core.
// Optional feature macro: STOPWATCH_LAP_EN (adds lap_pulse / lap_active and
// display hold registers; default build has neither).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick_1hz     : one-cycle count enable
//   tick_adj     : one-cycle adjust-rate enable
//   clear_pulse  : clear both fields and expired (highest priority)
//   pause_pulse  : toggle paused
//   adj, sel     : adjust mode level; sel=1 seconds, sel=0 minutes
//   mode         : 0 count up, 1 count down
//   min_cnt, sec_cnt : displayed value
//   paused, expired, rollover : status (all registered)
//   lap_pulse, lap_active     : lap hold toggle / state (STOPWATCH_LAP_EN)
// Per-cycle priority: clear > pause > adjust > count; only one acts.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD = SEC_MOD_DEFAULT,
    parameter int MIN_MOD = MIN_MOD_DEFAULT,
    parameter int SEC_W   = $clog2(SEC_MOD),
    parameter int MIN_W   = $clog2(MIN_MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_adj,
    input  logic             clear_pulse,
    input  logic             pause_pulse,
    input  logic             adj,
    input  logic             sel,
    input  logic             mode,
`ifdef STOPWATCH_LAP_EN
    input  logic             lap_pulse,
    output logic             lap_active,
`endif
    output logic [MIN_W-1:0] min_cnt,
    output logic [SEC_W-1:0] sec_cnt,
    output logic             paused,
    output logic             expired,
    output logic             rollover
);

    logic paused_q,   paused_d;
    logic expired_q,  expired_d;
    logic rollover_q, rollover_d;

    logic [SEC_W-1:0] sec_live;
    logic [MIN_W-1:0] min_live;
    logic             sec_carry, sec_borrow;
    logic             min_carry;
    // A minutes borrow would need a decrement from 00:00, which holds instead.
    logic             min_borrow_unused;

    logic ev_pause, active, adj_inc, cnt_up, cnt_down, at_zero;
    logic sec_inc, sec_dec, min_inc, min_dec;

    always_comb begin
        ev_pause = !clear_pulse && pause_pulse;
        // Ticks only act when neither clear nor pause claimed the cycle.
        active   = !clear_pulse && !pause_pulse && !paused_q;
        adj_inc  = active && adj && tick_adj;
        cnt_up   = active && !adj && tick_1hz && (mode == MODE_UP);
        cnt_down = active && !adj && tick_1hz && (mode == MODE_DOWN);
        at_zero  = (sec_live == '0) && (min_live == '0);

        // Adjust increments never carry between fields.
        sec_inc  = cnt_up || (adj_inc && sel);
        sec_dec  = cnt_down && !at_zero;
        min_inc  = (cnt_up && sec_carry) || (adj_inc && !sel);
        min_dec  = cnt_down && !at_zero && sec_borrow;
    end

    mod_field #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .inc    (sec_inc),
        .dec    (sec_dec),
        .clr    (clear_pulse),
        .val    (sec_live),
        .carry  (sec_carry),
        .borrow (sec_borrow)
    );

    mod_field #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk    (clk),
        .rst    (rst),
        .inc    (min_inc),
        .dec    (min_dec),
        .clr    (clear_pulse),
        .val    (min_live),
        .carry  (min_carry),
        .borrow (min_borrow_unused)
    );

    always_comb begin
        paused_d   = ev_pause ? !paused_q : paused_q;
        // Minutes only carry from a count-up tick when the whole value wraps.
        rollover_d = cnt_up && min_carry;

        expired_d = expired_q;
        if (clear_pulse || adj_inc) begin
            expired_d = 1'b0;
        end else if (cnt_down && (min_live == '0) &&
                     ((sec_live == '0) || (sec_live == SEC_W'(1)))) begin
            // Either already at 00:00 (holding) or this tick lands on 00:00.
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paused_q   <= 1'b0;
            expired_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            paused_q   <= paused_d;
            expired_q  <= expired_d;
            rollover_q <= rollover_d;
        end
    end

    assign paused   = paused_q;
    assign expired  = expired_q;
    assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic             lap_q, lap_d;
    logic [SEC_W-1:0] disp_sec_q, disp_sec_d;
    logic [MIN_W-1:0] disp_min_q, disp_min_d;

    always_comb begin
        lap_d      = lap_q;
        disp_sec_d = disp_sec_q;
        disp_min_d = disp_min_q;
        if (clear_pulse) begin
            lap_d = 1'b0;
        end else if (lap_pulse) begin
            lap_d = !lap_q;
            // Entering the hold snapshots the value shown in this cycle.
            if (!lap_q) begin
                disp_sec_d = sec_live;
                disp_min_d = min_live;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q      <= 1'b0;
            disp_sec_q <= '0;
            disp_min_q <= '0;
        end else begin
            lap_q      <= lap_d;
            disp_sec_q <= disp_sec_d;
            disp_min_q <= disp_min_d;
        end
    end

    assign lap_active = lap_q;
    assign sec_cnt    = lap_q ? disp_sec_q : sec_live;
    assign min_cnt    = lap_q ? disp_min_q : min_live;
`else
    assign sec_cnt = sec_live;
    assign min_cnt = min_live;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
module tb_stopwatch_timer;

    localparam int SM = 60;
    localparam int MM = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 0, tick_adj = 0, clear_pulse = 0, pause_pulse = 0;
    logic adj = 0, sel = 0, mode = 0;
    logic [5:0] min_cnt, sec_cnt;
    logic paused, expired, rollover;
`ifdef STOPWATCH_LAP_EN
    logic lap_pulse = 0;
    logic lap_active;
`endif

    stopwatch_timer #(.SEC_MOD(SM), .MIN_MOD(MM)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_adj    (tick_adj),
        .clear_pulse (clear_pulse),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .mode        (mode),
`ifdef STOPWATCH_LAP_EN
        .lap_pulse   (lap_pulse),
        .lap_active  (lap_active),
`endif
        .min_cnt     (min_cnt),
        .sec_cnt     (sec_cnt),
        .paused      (paused),
        .expired     (expired),
        .rollover    (rollover)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the live time is kept as total seconds.
    int m_t = 0;
    int m_paused = 0, m_exp = 0, m_roll = 0, m_lap = 0, m_disp = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_paused = 0; m_exp = 0; m_roll = 0; m_lap = 0; m_disp = 0;
    endtask

    task automatic model_step(input int clr, input int pau, input int t1, input int ta,
                              input int a, input int s, input int md, input int lp);
        m_roll = 0;
        if (clr != 0) begin
            m_t = 0; m_exp = 0; m_lap = 0;
        end else begin
            if (lp != 0) begin
                if (m_lap == 0) m_disp = m_t;
                m_lap = 1 - m_lap;
            end
            if (pau != 0) begin
                m_paused = 1 - m_paused;
            end else if (m_paused == 0) begin
                if (a != 0) begin
                    if (ta != 0) begin
                        if (s != 0) m_t = (m_t / SM) * SM + ((m_t % SM) + 1) % SM;
                        else        m_t = (((m_t / SM) + 1) % MM) * SM + (m_t % SM);
                        m_exp = 0;
                    end
                end else if (t1 != 0) begin
                    if (md == 0) begin
                        if (m_t == SM * MM - 1) begin m_t = 0; m_roll = 1; end
                        else m_t = m_t + 1;
                    end else begin
                        if (m_t == 0) m_exp = 1;
                        else begin
                            m_t = m_t - 1;
                            if (m_t == 0) m_exp = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int shown;
        shown = (m_lap != 0) ? m_disp : m_t;
        check({tag, ".min"}, int'(min_cnt), shown / SM);
        check({tag, ".sec"}, int'(sec_cnt), shown % SM);
        check({tag, ".paused"}, int'(paused), m_paused);
        check({tag, ".expired"}, int'(expired), m_exp);
        check({tag, ".rollover"}, int'(rollover), m_roll);
`ifdef STOPWATCH_LAP_EN
        check({tag, ".lap"}, int'(lap_active), m_lap);
`endif
    endtask

    // One clock cycle: drive inputs, advance model, check after the edge.
    task automatic cyc(input string tag, input int clr, input int pau, input int t1,
                       input int ta, input int a, input int s, input int md, input int lp);
        int lp_eff;
        clear_pulse = clr[0]; pause_pulse = pau[0]; tick_1hz = t1[0]; tick_adj = ta[0];
        adj = a[0]; sel = s[0]; mode = md[0];
`ifdef STOPWATCH_LAP_EN
        lap_pulse = lp[0];
        lp_eff = lp;
`else
        lp_eff = 0;
`endif
        @(posedge clk);
        model_step(clr, pau, t1, ta, a, s, md, lp_eff);
        #1;
        check_model(tag);
        clear_pulse = 0; pause_pulse = 0; tick_1hz = 0; tick_adj = 0;
`ifdef STOPWATCH_LAP_EN
        lap_pulse = 0;
`endif
    endtask

    task automatic idle(input string tag);            cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic clr(input string tag);             cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tick(input string tag, input int md); cyc(tag, 0, 0, 1, 0, 0, 0, md, 0); endtask
    task automatic adj_n(input int s, input int n);
        for (int i = 0; i < n; i++) cyc("adjset", 0, 0, 0, 1, 1, s, 0, 0);
    endtask
    task automatic show(input string tag, input int mn, input int sc);
        check({tag, ".min_abs"}, int'(min_cnt), mn);
        check({tag, ".sec_abs"}, int'(sec_cnt), sc);
    endtask

    initial begin
        model_reset();
        #1;
        check("reset.min", int'(min_cnt), 0);
        check("reset.sec", int'(sec_cnt), 0);
        check("reset.paused", int'(paused), 0);
        check("reset.expired", int'(expired), 0);
        check("reset.rollover", int'(rollover), 0);
        @(posedge clk); #1;
        rst = 0;
        idle("idle0");

        // Up count across a minute boundary.
        adj_n(1, 58);
        show("at0058", 0, 58);
        tick("up1", 0); show("up1", 0, 59);
        tick("up2", 0); show("up2", 1, 0);
        tick("up3", 0); show("up3", 1, 1);

        // Full wrap with rollover.
        clr("clr1");
        adj_n(0, 59); adj_n(1, 59);
        show("at5959", 59, 59);
        tick("wrap", 0); show("wrap", 0, 0);
        check("wrap.roll_abs", int'(rollover), 1);
        idle("wrap.after");
        check("wrap.roll_drop", int'(rollover), 0);

        // Down count.
        clr("clr2"); adj_n(0, 1);
        tick("dn1", 1); show("dn1", 0, 59);
        clr("clr3"); adj_n(1, 1);
        tick("dn0", 1); show("dn0", 0, 0);
        check("dn0.exp_abs", int'(expired), 1);
        tick("dnhold", 1); show("dnhold", 0, 0);
        check("dnhold.exp_abs", int'(expired), 1);
        clr("clrexp");
        check("clrexp.exp_abs", int'(expired), 0);

        // Pause.
        adj_n(1, 7);
        cyc("pause", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick("ptick", 0);
        show("paused", 0, 7);
        check("paused.abs", int'(paused), 1);
        cyc("resume", 0, 1, 0, 0, 0, 0, 0, 0);
        tick("resumed", 0); show("resumed", 0, 8);
        cyc("pausetick", 0, 1, 1, 0, 0, 0, 0, 0); show("pausetick", 0, 8);
        cyc("resume2", 0, 1, 0, 0, 0, 0, 0, 0);

        // Adjust: no carry, tick_1hz ignored.
        clr("clr4"); adj_n(1, 59);
        cyc("adjsec", 0, 0, 1, 1, 1, 1, 0, 0); show("adjsec", 0, 0);
        clr("clr5"); adj_n(0, 59); adj_n(1, 10);
        cyc("adjmin", 0, 0, 1, 1, 1, 0, 0, 0); show("adjmin", 0, 10);
        cyc("adjign", 0, 0, 1, 0, 1, 0, 1, 0); show("adjign", 0, 10);

        // Asynchronous reset between edges at 12:34.
        clr("clr6"); adj_n(0, 12); adj_n(1, 34);
        show("at1234", 12, 34);
        #3 rst = 1;
        #1;
        show("arst", 0, 0);
        check("arst.paused", int'(paused), 0);
        check("arst.expired", int'(expired), 0);
        model_reset();
        @(posedge clk); #1; rst = 0;
        tick("postrst", 0); show("postrst", 0, 1);

        // Clear beats pause.
        cyc("clrpause", 1, 1, 0, 0, 0, 0, 0, 0);
        check("clrpause.paused", int'(paused), 0);

`ifdef STOPWATCH_LAP_EN
        adj_n(1, 10);
        cyc("lapin", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick("laptick", 0);
        show("laphold", 0, 10);
        cyc("lapout", 0, 0, 0, 0, 0, 0, 0, 1);
        show("lapout", 0, 15);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc("rand",
                ($urandom_range(0, 99) < 2) ? 1 : 0,
                ($urandom_range(0, 99) < 4) ? 1 : 0,
                ($urandom_range(0, 99) < 60) ? 1 : 0,
                ($urandom_range(0, 99) < 30) ? 1 : 0,
                ($urandom_range(0, 99) < 20) ? 1 : 0,
                int'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 40) ? 1 : 0,
                ($urandom_range(0, 99) < 3) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
